// File: rtl/sync_fifo_row_packer.sv
// sync_fifo_row_packer
// Packs WWIDTH-bit SPI words MSB-first into one DWIDTH-bit row and pushes
// each completed row into the sync FIFO write port (wr_en/wdata/full).
//
// Optional feature macro: ROW_TAG_CHK_EN
//   When defined, the low byte of every pushed row is checked against a
//   running expected tag, and the sticky tag_err output is added.
//
// Handshake: a word is taken on any cycle where word_vld && word_rdy.
// word_rdy is high only in COLLECT. A word offered while word_rdy=0 is
// dropped and sets the sticky ovf flag. wr_en is a single-cycle write
// strobe, issued only while full=0. There is no back-pressure on wr_en
// beyond full.
module sync_fifo_row_packer #(
  parameter int DWIDTH = 136,
  parameter int WWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              word_vld,
  input  logic [WWIDTH-1:0] word_data,
  output logic              word_rdy,
  input  logic              row_clr,
  input  logic              full,
  output logic              wr_en,
  output logic [DWIDTH-1:0] wdata,
  output logic [3:0]        word_idx,
  output logic [7:0]        row_cnt,
  output logic              ovf,
`ifdef ROW_TAG_CHK_EN
  output logic              tag_err,
`endif
  output logic [1:0]        dbg_state
);

  localparam int NWORDS = (DWIDTH + WWIDTH - 1) / WWIDTH;
  // Bits the final word contributes to the bottom of the row.
  localparam int LASTW = DWIDTH - (NWORDS - 1) * WWIDTH;
  localparam logic [3:0] LAST_IDX = 4'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_PUSH    = 2'd1,
    ST_WAIT    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          word_idx_q, word_idx_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [7:0]          row_cnt_q, row_cnt_d;
  logic                ovf_q, ovf_d;

  assign word_rdy  = (state_q == ST_COLLECT);
  assign wdata     = wdata_q;
  assign word_idx  = word_idx_q;
  assign row_cnt   = row_cnt_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

  // Register all packer state; async reset returns to an empty COLLECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_COLLECT;
      word_idx_q <= 4'd0;
      wdata_q    <= '0;
      row_cnt_q  <= 8'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      wdata_q    <= wdata_d;
      row_cnt_q  <= row_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state, word packing and the FIFO write strobe.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    wdata_d    = wdata_q;
    row_cnt_d  = row_cnt_q;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;

    if (row_clr) begin
      // Abort wins over everything: drop the row (partial or pending) and
      // clear the whole row register so no stale bits survive.
      state_d    = ST_COLLECT;
      word_idx_d = 4'd0;
      wdata_d    = '0;
      ovf_d      = 1'b0;
    end else begin
      if (word_vld && !word_rdy) begin
        ovf_d = 1'b1;
      end
      case (state_q)
        ST_COLLECT: begin
          if (word_vld) begin
            for (int k = 0; k < NWORDS - 1; k++) begin
              if (word_idx_q == 4'(k)) begin
                wdata_d[DWIDTH-1-k*WWIDTH -: WWIDTH] = word_data;
              end
            end
            if (word_idx_q == LAST_IDX) begin
              // Only the low LASTW bits of the final word are kept.
              wdata_d[LASTW-1:0] = word_data[LASTW-1:0];
              word_idx_d         = 4'd0;
              state_d            = ST_PUSH;
            end else begin
              word_idx_d = word_idx_q + 4'd1;
            end
          end
        end
        ST_PUSH, ST_WAIT: begin
          if (!full) begin
            wr_en     = 1'b1;
            row_cnt_d = row_cnt_q + 8'd1;
            state_d   = ST_COLLECT;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

`ifdef ROW_TAG_CHK_EN
  logic [7:0] exp_tag_q;
  logic       tag_err_q;

  assign tag_err = tag_err_q;

  // Track the expected row tag and latch any mismatch seen on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_tag_q <= 8'd0;
      tag_err_q <= 1'b0;
    end else begin
      if (wr_en) begin
        exp_tag_q <= wdata_q[7:0] + 8'd1;
      end
      if (row_clr) begin
        tag_err_q <= 1'b0;
      end else if (wr_en && (wdata_q[7:0] != exp_tag_q)) begin
        tag_err_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_row_packer.sv
// Directed bench for sync_fifo_row_packer: reset, single row, backpressure
// with dropped word, abort, streaming with row_cnt wrap, reset mid-row and
// mid-WAIT, and (with ROW_TAG_CHK_EN) the tag checker.
module tb_sync_fifo_row_packer;
  localparam int DW = 136;
  localparam int WW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          word_vld;
  logic [WW-1:0] word_data;
  logic          word_rdy;
  logic          row_clr;
  logic          full;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic [3:0]    word_idx;
  logic [7:0]    row_cnt;
  logic          ovf;
  logic [1:0]    dbg_state;
`ifdef ROW_TAG_CHK_EN
  logic          tag_err;
`endif

  sync_fifo_row_packer #(.DWIDTH(DW), .WWIDTH(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .word_vld  (word_vld),
    .word_data (word_data),
    .word_rdy  (word_rdy),
    .row_clr   (row_clr),
    .full      (full),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .word_idx  (word_idx),
    .row_cnt   (row_cnt),
    .ovf       (ovf),
`ifdef ROW_TAG_CHK_EN
    .tag_err   (tag_err),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_pulses = 0;
  logic [7:0]    exp_rcnt = 8'd0;
  logic [DW-1:0] exp_q[$];
  logic [15:0]   words[9];

  task automatic check_eq(input string tag, input logic [DW-1:0] obs,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference row: eight full words shifted in MSB-first, then the low byte
  // of the ninth word.
  function automatic logic [DW-1:0] mk_row();
    logic [DW-1:0] row;
    row = '0;
    for (int k = 0; k < 8; k++) row = {row[DW-17:0], words[k]};
    row = {row[DW-9:0], words[8][7:0]};
    return row;
  endfunction

  task automatic expect_row();
    exp_q.push_back(mk_row());
    exp_rcnt = exp_rcnt + 8'd1;
  endtask

  // Every wr_en pulse must match the oldest expected row.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      n_pulses++;
      if (exp_q.size() == 0) check_eq("unexpected_wr_en", {135'd0, wr_en}, '0);
      else                   check_eq("row_wdata", wdata, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [15:0] d);
    word_vld  = 1'b1;
    word_data = d;
    tick();
    word_vld  = 1'b0;
  endtask

  task automatic send_row();
    for (int k = 0; k < 9; k++) send_word(words[k]);
  endtask

  task automatic stream_row(input logic [7:0] r);
    for (int k = 0; k < 9; k++) words[k] = {r, 8'(k)};
    expect_row();
    send_row();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; word_vld = 1'b0; word_data = '0; row_clr = 1'b0; full = 1'b0;
    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_wr_en",    wr_en,    0);
    check_eq("rst_wdata",    wdata,    0);
    check_eq("rst_word_idx", word_idx, 0);
    check_eq("rst_row_cnt",  row_cnt,  0);
    check_eq("rst_ovf",      ovf,      0);
    check_eq("rst_word_rdy", word_rdy, 1);
    tick();

    // Single row, one word every 8 cycles.
    for (int i = 0; i < 9; i++) words[i] = 16'(i + 1);
    expect_row();
    for (int i = 0; i < 9; i++) begin
      send_word(words[i]);
      if (i < 8) tick(7);
    end
    @(negedge clk);
    check_eq("t2_wr_en_push", wr_en, 1);
    check_eq("t2_rdy_push",   word_rdy, 0);
    tick();
    @(negedge clk);
    check_eq("t2_wr_en_after", wr_en, 0);
    check_eq("t2_row_cnt",     row_cnt, exp_rcnt);
    check_eq("t2_pulses",      n_pulses, 1);
    check_eq("t2_word_idx",    word_idx, 0);
    tick();

    // Backpressure plus one dropped word.
    full = 1'b1;
    for (int i = 0; i < 9; i++) words[i] = 16'h1100 + 16'(i);
    expect_row();
    send_row();
    @(negedge clk);
    check_eq("t3_wr_en_push", wr_en, 0);
    check_eq("t3_rdy_push",   word_rdy, 0);
    send_word(16'hDEAD);
    tick(2);
    @(negedge clk);
    check_eq("t3_ovf",       ovf, 1);
    check_eq("t3_wr_en_hold", wr_en, 0);
    check_eq("t3_rdy_wait",  word_rdy, 0);
    check_eq("t3_state",     dbg_state, 2);
    check_eq("t3_wdata_hold", wdata, mk_row());
    tick();
    full = 1'b0;
    @(negedge clk);
    check_eq("t3_wr_en_release", wr_en, 1);
    tick();
    @(negedge clk);
    check_eq("t3_wr_en_after", wr_en, 0);
    check_eq("t3_row_cnt",     row_cnt, exp_rcnt);
    check_eq("t3_pulses",      n_pulses, 2);
    check_eq("t3_rdy",         word_rdy, 1);
    tick();

    // Abort a row held in WAIT, with full dropping on the same cycle.
    full = 1'b1;
    for (int i = 0; i < 9; i++) words[i] = 16'h2200 + 16'(i);
    send_row();
    tick(2);
    full = 1'b0;
    row_clr = 1'b1;
    @(negedge clk);
    check_eq("clr_wait_wr_en", wr_en, 0);
    tick();
    row_clr = 1'b0;
    @(negedge clk);
    check_eq("clr_wait_rdy",     word_rdy, 1);
    check_eq("clr_wait_wdata",   wdata, 0);
    check_eq("clr_wait_ovf",     ovf, 0);
    check_eq("clr_wait_row_cnt", row_cnt, exp_rcnt);
    tick();

    // Abort a partial row, then pack a fresh one.
    for (int i = 0; i < 4; i++) send_word(16'hB000 + 16'(i));
    @(negedge clk);
    check_eq("t4_idx_partial", word_idx, 4);
    tick();
    row_clr = 1'b1;
    tick();
    row_clr = 1'b0;
    @(negedge clk);
    check_eq("t4_idx_clr",   word_idx, 0);
    check_eq("t4_ovf_clr",   ovf, 0);
    check_eq("t4_wdata_clr", wdata, 0);
    check_eq("t4_pulses",    n_pulses, 2);
    tick();
    for (int i = 0; i < 9; i++) words[i] = 16'hA000 + 16'(i);
    expect_row();
    send_row();
    @(negedge clk);
    check_eq("t4_wr_en", wr_en, 1);
    check_eq("t4_wdata", wdata, {16'hA000, 16'hA001, 16'hA002, 16'hA003,
                                 16'hA004, 16'hA005, 16'hA006, 16'hA007, 8'h08});
    tick();
    @(negedge clk);
    check_eq("t4_row_cnt", row_cnt, exp_rcnt);
    tick();

    // Streaming three rows back to back, then run row_cnt through its wrap.
    for (int r = 0; r < 3; r++) stream_row(8'(r));
    @(negedge clk);
    check_eq("t5_pulses",  n_pulses, 6);
    check_eq("t5_row_cnt", row_cnt, exp_rcnt);
    check_eq("t5_ovf",     ovf, 0);
    tick();
    while (exp_rcnt != 8'd0) stream_row(exp_rcnt);
    @(negedge clk);
    check_eq("t5_wrap_row_cnt", row_cnt, 0);
    check_eq("t5_wrap_pulses",  n_pulses, 256);
    tick();

    // Reset in the middle of a row.
    for (int i = 0; i < 5; i++) send_word(16'hC000 + 16'(i));
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rmid_word_idx", word_idx, 0);
    check_eq("rmid_wdata",    wdata, 0);
    check_eq("rmid_rdy",      word_rdy, 1);
    check_eq("rmid_wr_en",    wr_en, 0);
    tick(2);
    rst_n = 1'b1;
    exp_rcnt = 8'd0;
    tick();

    // Reset while a row waits on full; the release of full must not write.
    full = 1'b1;
    for (int i = 0; i < 9; i++) words[i] = 16'hD000 + 16'(i);
    send_row();
    tick(2);
    full  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rwait_wr_en", wr_en, 0);
    check_eq("rwait_state", dbg_state, 0);
    check_eq("rwait_row_cnt", row_cnt, 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    stream_row(8'h5A);
    @(negedge clk);
    check_eq("post_rst_row_cnt", row_cnt, 1);
    tick();

`ifdef ROW_TAG_CHK_EN
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    exp_rcnt = 8'd0;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) words[k] = 16'h3000 + 16'(k);
      words[8] = (r == 2) ? 16'h0003 : 16'(r);
      expect_row();
      send_row();
      tick();
      @(negedge clk);
      check_eq("tag_err_row", tag_err, (r == 2) ? 1 : 0);
      tick();
    end
    row_clr = 1'b1;
    tick();
    row_clr = 1'b0;
    @(negedge clk);
    check_eq("tag_err_clr", tag_err, 0);
    tick();
`endif

    tick(3);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
